// File: rtl/pipe_hazard_unit_if.sv
// Decode-to-hazard-unit bundle: per-instruction D-stage info in, stall and forward selects out.
// The mult/div signals exist only when HAZ_MD_EN is defined.
interface pipe_hazard_unit_if #(
    parameter int AW = 5,
    parameter int TW = 2
);
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic [TW-1:0] d_rs_tuse;
    logic [TW-1:0] d_rt_tuse;
    logic [AW-1:0] d_dst;
    logic [TW-1:0] d_tnew;
    logic          stall;
    logic [1:0]    fwd_rs_d;
    logic [1:0]    fwd_rt_d;
    logic [1:0]    fwd_rs_e;
    logic [1:0]    fwd_rt_e;
    logic          fwd_rt_m;
`ifdef HAZ_MD_EN
    logic          md_start;
    logic          md_is_div;
    logic          d_md_use;
    logic          md_busy;

    modport master (
        output d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
        output md_start, md_is_div, d_md_use,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );
    modport slave (
        input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
        input  md_start, md_is_div, d_md_use,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );
`else
    modport master (
        output d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
    );
    modport slave (
        input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
    );
`endif
endinterface

// File: rtl/pipe_hazard_unit.sv
// Tuse/Tnew hazard unit for a 5-stage pipeline: tracks E/M/W destination records, drives stall and forwards.
// Define HAZ_MD_EN to add the mult/div busy counter and its HI/LO interlock.
module pipe_hazard_unit #(
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_unit_if.slave hz
);
    localparam logic [TW-1:0] TUSE_NONE = '1;

    logic [AW-1:0] e_rs, e_rt, e_dst, m_rt, m_dst, w_dst;
    logic [TW-1:0] e_rs_tuse, e_rt_tuse, e_tnew, m_rt_tuse, m_tnew;
    logic          rs_haz, rt_haz, stall;
    logic          unused_tuse;

    // All-ones marks an unused source and must survive the per-stage decrement.
    function automatic logic [TW-1:0] tuse_step(input logic [TW-1:0] t);
        if (t == TUSE_NONE || t == '0) return t;
        return t - 1'b1;
    endfunction

    function automatic logic [TW-1:0] tnew_step(input logic [TW-1:0] t);
        if (t == '0) return t;
        return t - 1'b1;
    endfunction

    function automatic logic src_haz(input logic [AW-1:0] s, input logic [TW-1:0] tuse,
                                     input logic [AW-1:0] edst, input logic [TW-1:0] etnew,
                                     input logic [AW-1:0] mdst, input logic [TW-1:0] mtnew);
        if (s == '0 || tuse == TUSE_NONE) return 1'b0;
        return ((edst == s) && (etnew > tuse)) || ((mdst == s) && (mtnew > tuse));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] s, input logic [AW-1:0] mdst,
                                           input logic [TW-1:0] mtnew, input logic [AW-1:0] wdst);
        if (s == '0) return 2'd0;
        if (mdst == s && mtnew == '0) return 2'd1;
        if (wdst == s) return 2'd2;
        return 2'd0;
    endfunction

    assign rs_haz = src_haz(hz.d_rs, hz.d_rs_tuse, e_dst, e_tnew, m_dst, m_tnew);
    assign rt_haz = src_haz(hz.d_rt, hz.d_rt_tuse, e_dst, e_tnew, m_dst, m_tnew);

`ifdef HAZ_MD_EN
    localparam int MD_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic [CW-1:0] md_cnt;
    logic          md_busy;

    assign md_busy    = (md_cnt != '0) || hz.md_start;
    assign hz.md_busy = md_busy;
    assign stall      = rs_haz || rt_haz || (hz.d_md_use && md_busy);

    // A new start reloads even when the unit is still busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (hz.md_start && !stall) begin
            md_cnt <= hz.md_is_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end
`else
    assign stall = rs_haz || rt_haz;
`endif

    assign hz.stall    = stall;
    assign hz.fwd_rs_d = fwd_sel(hz.d_rs, m_dst, m_tnew, w_dst);
    assign hz.fwd_rt_d = fwd_sel(hz.d_rt, m_dst, m_tnew, w_dst);
    assign hz.fwd_rs_e = fwd_sel(e_rs, m_dst, m_tnew, w_dst);
    assign hz.fwd_rt_e = fwd_sel(e_rt, m_dst, m_tnew, w_dst);
    assign hz.fwd_rt_m = (m_rt != '0) && (w_dst == m_rt);

    // Source timing is carried along with each record but no output needs it past D.
    assign unused_tuse = ^{e_rs_tuse, m_rt_tuse};

    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs      <= '0;
            e_rt      <= '0;
            e_rs_tuse <= TUSE_NONE;
            e_rt_tuse <= TUSE_NONE;
            e_dst     <= '0;
            e_tnew    <= '0;
            m_rt      <= '0;
            m_rt_tuse <= TUSE_NONE;
            m_dst     <= '0;
            m_tnew    <= '0;
            w_dst     <= '0;
        end else begin
            if (stall) begin
                e_rs      <= '0;
                e_rt      <= '0;
                e_rs_tuse <= TUSE_NONE;
                e_rt_tuse <= TUSE_NONE;
                e_dst     <= '0;
                e_tnew    <= '0;
            end else begin
                e_rs      <= hz.d_rs;
                e_rt      <= hz.d_rt;
                e_rs_tuse <= tuse_step(hz.d_rs_tuse);
                e_rt_tuse <= tuse_step(hz.d_rt_tuse);
                e_dst     <= hz.d_dst;
                e_tnew    <= hz.d_tnew;
            end
            m_rt      <= e_rt;
            m_rt_tuse <= tuse_step(e_rt_tuse);
            m_dst     <= e_dst;
            m_tnew    <= tnew_step(e_tnew);
            w_dst     <= m_dst;
        end
    end
endmodule
